// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
// Holds the FSM state enum and hold-counter sizing helper.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 8;

    function automatic int hold_width(input int mh);
        return (mh < 1) ? 1 : $clog2(mh + 1);
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotated priority search: first set request at or after ptr,
// wrapping N-1 -> 0.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N   = ARB_N_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] win_o,
    output logic           found_o
);
    localparam int SW = IDW + 1;

    logic [SW-1:0] idx;

    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k stays below 2N, so one subtract wraps it
            idx = {1'b0, ptr_i} + SW'(k);
            if (idx >= SW'(N)) begin
                idx = idx - SW'(N);
            end
            if (!found_o && req_i[idx[IDW-1:0]]) begin
                found_o = 1'b1;
                win_o   = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter with registered one-hot grant and optional
// hold limit that preempts a long-running owner.
module arb_rr
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic           preempt
);
    localparam int HW = hold_width(MAX_HOLD);
    localparam logic [HW-1:0] HMAX =
        (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST = IDW'(N - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           vld_q;
    logic           pre_q, pre_d;

    logic [IDW-1:0] nxt;
    logic [IDW-1:0] start;
    logic [IDW-1:0] win;
    logic [N-1:0]   req_m;
    logic           found;
    logic           expired;

    assign nxt     = (id_q == LAST) ? '0 : id_q + IDW'(1);
    assign start   = (state_q == ARB_BUSY) ? nxt : ptr_q;
    assign expired = (MAX_HOLD != 0) && (hold_q == HMAX);
    // the owner never competes against itself at a handoff
    assign req_m   = req & ~gnt_q;

    arb_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i   (req_m),
        .ptr_i   (start),
        .win_o   (win),
        .found_o (found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        pre_d   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_BUSY;
                    gnt_d   = N'(1) << win;
                    id_d    = win;
                    hold_d  = HW'(1);
                end
            end
            ARB_BUSY: begin
                if (!req[id_q]) begin
                    ptr_d = nxt;
                    if (found) begin
                        gnt_d  = N'(1) << win;
                        id_d   = win;
                        hold_d = HW'(1);
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        hold_d  = '0;
                    end
                end else if (expired) begin
                    hold_d = HW'(1);
                    if (found) begin
                        ptr_d = nxt;
                        gnt_d = N'(1) << win;
                        id_d  = win;
                        pre_d = 1'b1;
                    end
                end else if (hold_q != HMAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            vld_q   <= (state_d == ARB_BUSY);
            pre_q   <= pre_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = vld_q;
    assign gnt_id  = id_q;
    assign preempt = pre_q;

endmodule

// File: tb/tb_arb_rr.sv
// Scoreboard bench for arb_rr: three instances (N=4/MH=3,
// N=4/MH=0, N=5/MH=4) checked against an integer-level model.
module tb_arb_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] reqA, reqB;
    logic [4:0] reqC;
    logic [3:0] gA, gB;
    logic [4:0] gC;
    logic       vA, vB, vC, pA, pB, pC;
    logic [1:0] iA, iB;
    logic [2:0] iC;

    arb_rr #(.N(4), .MAX_HOLD(3)) dA (
        .clk(clk), .rst(rst), .req(reqA), .gnt(gA),
        .gnt_vld(vA), .gnt_id(iA), .preempt(pA)
    );
    arb_rr #(.N(4), .MAX_HOLD(0)) dB (
        .clk(clk), .rst(rst), .req(reqB), .gnt(gB),
        .gnt_vld(vB), .gnt_id(iB), .preempt(pB)
    );
    arb_rr #(.N(5), .MAX_HOLD(4)) dC (
        .clk(clk), .rst(rst), .req(reqC), .gnt(gC),
        .gnt_vld(vC), .gnt_id(iC), .preempt(pC)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int owner;
        int ptr;
        int hold;
    } mst_t;

    typedef struct {
        int gnt;
        int id;
        int pre;
    } exp_t;

    mst_t mA, mB, mC;
    exp_t qA[$], qB[$], qC[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wt[5];
    int   wmax = 0;
    bit   bOn = 0;
    bit   rOn = 0;

    int a32g[10] = '{2, 2, 2, 8, 8, 8, 2, 2, 2, 8};
    int a32p[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int b31i[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endfunction

    function automatic int rr(int r, int st, int n, int excl);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (st + k) % n;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic mst_t mrst();
        mst_t s;
        s.owner = -1;
        s.ptr   = 0;
        s.hold  = 0;
        return s;
    endfunction

    task automatic mstep(inout mst_t s, input int r, input int n,
                         input int mh, input bit rs,
                         output exp_t e);
        int w;
        e.pre = 0;
        if (rs) begin
            s = mrst();
        end else if (s.owner < 0) begin
            w = rr(r, s.ptr, n, -1);
            if (w >= 0) begin
                s.owner = w;
                s.hold  = 1;
            end
        end else if (!r[s.owner]) begin
            s.ptr   = (s.owner + 1) % n;
            w       = rr(r, s.ptr, n, -1);
            s.owner = w;
            s.hold  = (w >= 0) ? 1 : 0;
        end else if (mh != 0 && s.hold == mh) begin
            w = rr(r, (s.owner + 1) % n, n, s.owner);
            if (w >= 0) begin
                s.ptr   = (s.owner + 1) % n;
                s.owner = w;
                e.pre   = 1;
            end
            s.hold = 1;
        end else if (mh == 0 || s.hold < mh) begin
            s.hold++;
        end
        e.gnt = (s.owner < 0) ? 0 : (1 << s.owner);
        e.id  = (s.owner < 0) ? 0 : s.owner;
    endtask

    // requests rise at random and are held until the owner lets go
    task automatic rnd(inout int r, input int n, input int owner);
        for (int i = 0; i < n; i++) begin
            if (!r[i]) begin
                if ($urandom_range(2) == 0) r[i] = 1'b1;
            end else if (owner == i) begin
                if ($urandom_range(3) == 0) r[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        int   r;
        if (bOn) begin
            reqB = 4'hF;
            if (mB.owner >= 0 && mB.hold == 2)
                reqB[mB.owner] = 1'b0;
        end
        if (rOn) begin
            r = int'(reqA); rnd(r, 4, mA.owner); reqA = r[3:0];
            r = int'(reqB); rnd(r, 4, mB.owner); reqB = r[3:0];
            r = int'(reqC); rnd(r, 5, mC.owner); reqC = r[4:0];
        end
        mstep(mA, int'(reqA), 4, 3, rst, e); qA.push_back(e);
        mstep(mB, int'(reqB), 4, 0, rst, e); qB.push_back(e);
        mstep(mC, int'(reqC), 5, 4, rst, e); qC.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qA.size() > 0) begin
                e = qA.pop_front();
                chk("A.gnt", int'(gA), e.gnt);
                chk("A.vld", int'(vA), int'(e.gnt != 0));
                chk("A.id", int'(iA), e.id);
                chk("A.preempt", int'(pA), e.pre);
            end
            if (qB.size() > 0) begin
                e = qB.pop_front();
                chk("B.gnt", int'(gB), e.gnt);
                chk("B.vld", int'(vB), int'(e.gnt != 0));
                chk("B.id", int'(iB), e.id);
                chk("B.preempt", int'(pB), e.pre);
            end
            if (qC.size() > 0) begin
                e = qC.pop_front();
                chk("C.gnt", int'(gC), e.gnt);
                chk("C.vld", int'(vC), int'(e.gnt != 0));
                chk("C.id", int'(iC), e.id);
                chk("C.preempt", int'(pC), e.pre);
            end
            chk("C.onehot0", int'($onehot0(gC)), 1);
            if (!rst) begin
                for (int i = 0; i < 5; i++) begin
                    if (gC[i]) begin
                        wt[i] = 0;
                    end else if (reqC[i]) begin
                        wt[i]++;
                        if (wt[i] > wmax) wmax = wt[i];
                    end
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        reqA = 4'b0100;
        reqB = '0;
        reqC = '0;
        mA = mrst(); mB = mrst(); mC = mrst();
        for (int i = 0; i < 5; i++) wt[i] = 0;
        tick();
        tick();
        chk("rst.gnt_held_in_reset", int'(gA), 0);
        rst = 1'b0;

        tick();
        chk("030.gnt", int'(gA), 4);
        chk("030.id", int'(iA), 2);
        reqA = '0;
        tick();
        chk("030.release", int'(gA), 0);

        reqA = 4'b0100;
        tick();
        chk("034.before", int'(gA), 4);
        rst = 1'b1;
        #1;
        chk("034.async_gnt", int'(gA), 0);
        chk("034.async_vld", int'(vA), 0);
        chk("034.async_id", int'(iA), 0);
        rst = 1'b0;
        mA = mrst(); mB = mrst(); mC = mrst();

        reqA = 4'b1010;
        bOn  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("032.gnt", int'(gA), a32g[k]);
            chk("032.preempt", int'(pA), a32p[k]);
            chk("031.id", int'(iB), b31i[k]);
            chk("031.vld", int'(vB), 1);
        end
        bOn  = 1'b0;
        reqB = '0;

        reqA = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("033.gnt", int'(gA), 1);
            chk("033.preempt", int'(pA), 0);
        end

        reqA = '0;
        tick();
        for (int i = 0; i < 5; i++) wt[i] = 0;
        wmax = 0;
        rOn  = 1'b1;
        for (int k = 0; k < 10000; k++) tick();
        rOn  = 1'b0;
        @(posedge clk);
        #2;

        n_cmp++;
        if (wmax > 17) begin
            n_bad++;
            $display("FAIL 035.max_wait: got %0d, want <= 17", wmax);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arb_rr.md
ARB_RR -- requirements
Module: arb_rr

Interface
REQ-001 Parameter N, default 4, number of requestors; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8, max consecutive grant cycles per owner; 0 = unlimited.
REQ-003 Parameter IDW, default $clog2(N), width of gnt_id.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N  per-requestor request, level-sensitive, held until served.
REQ-007 gnt  output  N  registered one-hot grant; all-zero when idle.
REQ-008 gnt_vld  output  1  high when any gnt bit is set.
REQ-009 gnt_id  output  IDW  index of the set gnt bit; 0 when gnt_vld is low.
REQ-010 preempt  output  1  one-cycle pulse when an owner loses grant by MAX_HOLD expiry.

Function
REQ-011 The FSM SHALL have two states: IDLE (no owner) and BUSY (one owner, gnt one-hot).
REQ-012 Priority pointer ptr (IDW bits): search starts at ptr, wraps N-1 -> 0; first set req bit wins.
REQ-013 IDLE, any req bit sampled high at edge k: gnt set after edge k (1-cycle latency), state BUSY, hold_cnt = 1.
REQ-014 IDLE, req all zero: gnt stays zero, ptr unchanged.
REQ-015 BUSY, req[owner] high, hold not expired: gnt unchanged, hold_cnt increments, saturating at MAX_HOLD.
REQ-016 Hold expired = MAX_HOLD != 0 and hold_cnt == MAX_HOLD at the sampling edge.
REQ-017 BUSY, owner drops req: ptr = owner+1 mod N; with another req pending, gnt moves directly to the RR winner from the new ptr at the same edge, no idle cycle.
REQ-018 If REQ-017 finds no other req pending: gnt clears, state IDLE.
REQ-019 BUSY, hold expired, owner still requesting, another req pending: gnt moves to the RR winner from owner+1; preempt pulses for one cycle, coincident with the new gnt.
REQ-020 BUSY, hold expired, no other req pending: owner keeps gnt; hold_cnt restarts at 1; no preempt.
REQ-021 On every grant change, hold_cnt SHALL load 1.
REQ-022 gnt SHALL never have more than one bit set; gnt_id and gnt_vld are registered together with gnt.
REQ-023 Requests asserted while not owner SHALL have no effect on gnt until a handoff point (REQ-017/019).
REQ-024 hold_cnt width = $clog2(MAX_HOLD+1), minimum 1; no wrap.

Reset
REQ-025 On rst high, asynchronously: gnt=0, gnt_vld=0, gnt_id=0, preempt=0, ptr=0, hold_cnt=0, state IDLE.
REQ-026 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge; after release, the first arbitration starts from ptr=0.
REQ-027 No grant SHALL be issued at the first edge on which rst is still high.

Structure
REQ-028 Package arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_BUSY) and the N/MAX_HOLD default constants.
REQ-029 Sub-module arb_rr_pick (combinational: req, ptr -> winner index, found) SHALL implement the rotated priority search; arb_rr instantiates it once.

Verification
REQ-030 N=4: req=0100 after reset -> gnt=0100, gnt_id=2 one cycle later; req->0 -> gnt=0000 next cycle.
REQ-031 N=4: req=1111 held constant, MAX_HOLD=0; owner drops req for one cycle after 2 grant cycles, then re-requests -> grant order 0,1,2,3,0 with no idle cycles between owners.
REQ-032 N=4, MAX_HOLD=3: req[1] and req[3] held high -> gnt=0010 for 3 cycles, then gnt=1000 with preempt=1 for one cycle, then gnt=0010 after 3 cycles.
REQ-033 MAX_HOLD=3, only req[0] high for 10 cycles -> gnt=0001 all 10 cycles, preempt never asserts.
REQ-034 rst pulsed mid-grant (gnt=0100) between edges -> gnt=0000 before next edge; after release, req=1010 -> gnt=0010.
REQ-035 Random req, 10k cycles, N=5 -> gnt always one-hot or zero; no requestor waits more than (N-1)*MAX_HOLD+1 cycles.
